// File: rtl/jump_target_unit.sv
// Jump/call/return target selection for the program counter: software-loaded LUT plus return-address stack.
// Optional feature macro: JUMP_RAS_EN (return-address stack, depth counter and fault flags).
module jump_target_unit #(
  parameter int D = 12,
  parameter int L = 4,
  parameter int S = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [D-1:0]           prog_ctr,
  input  logic                   jump_req,
  input  logic                   jump_cond,
  input  logic                   call_req,
  input  logic                   ret_req,
  input  logic [L-1:0]           lut_idx,
  input  logic                   lut_we,
  input  logic [L-1:0]           lut_waddr,
  input  logic [D-1:0]           lut_wdata,
  input  logic                   fault_clr,
  output logic                   absjump_en,
  output logic [D-1:0]           target,
  output logic [$clog2(S+1)-1:0] ras_depth,
  output logic                   ovf_fault,
  output logic                   unf_fault
);

  localparam int N = 2 ** L;

  logic [D-1:0] lut_q [N];
  logic [D-1:0] lut_d [N];
  logic [D-1:0] lut_rdata;

  assign lut_rdata = lut_q[lut_idx];

  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d[lut_waddr] = lut_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) lut_q <= '{default: '0};
    else       lut_q <= lut_d;
  end

`ifdef JUMP_RAS_EN
  localparam int DW = $clog2(S + 1);
  localparam int AW = (S > 1) ? $clog2(S) : 1;

  logic [D-1:0]  ras_q [S];
  logic [D-1:0]  ras_d [S];
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          ras_full, ras_empty;
  logic [AW-1:0] top_idx, push_idx;
  logic          do_push, do_pop, ovf_event, unf_event;

  assign ras_full  = (depth_q == DW'(S));
  assign ras_empty = (depth_q == '0);
  assign top_idx   = AW'(depth_q - DW'(1));
  assign push_idx  = AW'(depth_q);

  // Lower-priority requests never touch the stack or raise faults when ret_req is present.
  assign do_pop    = ret_req && !ras_empty;
  assign unf_event = ret_req && ras_empty;
  assign do_push   = !ret_req && call_req && !ras_full;
  assign ovf_event = !ret_req && call_req && ras_full;

  always_comb begin
    ras_d   = ras_q;
    depth_d = depth_q;
    if (do_push) begin
      ras_d[push_idx] = prog_ctr + D'(1);
      depth_d         = depth_q + DW'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // A fault event in the same cycle as fault_clr leaves the flag set.
  always_comb begin
    ovf_d = ovf_event || (ovf_q && !fault_clr);
    unf_d = unf_event || (unf_q && !fault_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is never cleared; only the pointer decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset) ras_q <= ras_d;
  end

  assign ras_depth = depth_q;
  assign ovf_fault = ovf_q;
  assign unf_fault = unf_q;
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = ^{prog_ctr, fault_clr};
  assign ras_depth         = '0;
  assign ovf_fault         = 1'b0;
  assign unf_fault         = 1'b0;
`endif

  always_comb begin
    absjump_en = 1'b0;
    target     = '0;
    if (!reset) begin
      if (ret_req) begin
`ifdef JUMP_RAS_EN
        if (!ras_empty) begin
          absjump_en = 1'b1;
          target     = ras_q[top_idx];
        end
`endif
      end else if (call_req) begin
`ifdef JUMP_RAS_EN
        if (!ras_full) begin
          absjump_en = 1'b1;
          target     = lut_rdata;
        end
`else
        absjump_en = 1'b1;
        target     = lut_rdata;
`endif
      end else if (jump_req && jump_cond) begin
        absjump_en = 1'b1;
        target     = lut_rdata;
      end
    end
  end

endmodule

// File: tb/tb_jump_target_unit.sv
// Self-checking bench for jump_target_unit: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_jump_target_unit;

  localparam int D = 12;
  localparam int L = 4;
  localparam int S = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [D-1:0]           prog_ctr;
  logic                   jump_req, jump_cond, call_req, ret_req;
  logic [L-1:0]           lut_idx;
  logic                   lut_we;
  logic [L-1:0]           lut_waddr;
  logic [D-1:0]           lut_wdata;
  logic                   fault_clr;
  logic                   absjump_en;
  logic [D-1:0]           target;
  logic [$clog2(S+1)-1:0] ras_depth;
  logic                   ovf_fault, unf_fault;

  int vectors     = 0;
  int miscompares = 0;

  jump_target_unit #(.D(D), .L(L), .S(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_ctr   (prog_ctr),
    .jump_req   (jump_req),
    .jump_cond  (jump_cond),
    .call_req   (call_req),
    .ret_req    (ret_req),
    .lut_idx    (lut_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .fault_clr  (fault_clr),
    .absjump_en (absjump_en),
    .target     (target),
    .ras_depth  (ras_depth),
    .ovf_fault  (ovf_fault),
    .unf_fault  (unf_fault)
  );

  always #5 clk = ~clk;

  // Reference model: plain LUT array, stack as a queue (back = top), sticky flags.
  logic [D-1:0] lutM [2**L];
  logic [D-1:0] rasM [$];
  bit           ovfM, unfM, modelValid = 0;
  bit           ovfEv, unfEv;
  bit           expEn;
  logic [D-1:0] expTgt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the PC must see this cycle, from request priority and current model state.
  task automatic computeExpected();
    expEn  = 0;
    expTgt = '0;
    if (!reset) begin
      if (ret_req) begin
`ifdef JUMP_RAS_EN
        if (rasM.size() > 0) begin
          expEn  = 1;
          expTgt = rasM[rasM.size()-1];
        end
`endif
      end else if (call_req) begin
`ifdef JUMP_RAS_EN
        if (rasM.size() < S) begin
          expEn  = 1;
          expTgt = lutM[lut_idx];
        end
`else
        expEn  = 1;
        expTgt = lutM[lut_idx];
`endif
      end else if (jump_req && jump_cond) begin
        expEn  = 1;
        expTgt = lutM[lut_idx];
      end
    end
  endtask

  // Model state advances on the same edge the DUT samples.
  always @(posedge clk) begin
    if (reset) begin
      foreach (lutM[i]) lutM[i] = '0;
      rasM.delete();
      ovfM       = 0;
      unfM       = 0;
      modelValid = 1;
    end else if (modelValid) begin
      ovfEv = 0;
      unfEv = 0;
`ifdef JUMP_RAS_EN
      if (ret_req) begin
        if (rasM.size() > 0) void'(rasM.pop_back());
        else unfEv = 1;
      end else if (call_req) begin
        if (rasM.size() < S) rasM.push_back(prog_ctr + 12'd1);
        else ovfEv = 1;
      end
`endif
      ovfM = ovfEv || (ovfM && !fault_clr);
      unfM = unfEv || (unfM && !fault_clr);
      if (lut_we) lutM[lut_waddr] = lut_wdata;
    end
  end

  // Every cycle after the first reset edge, all outputs must match the model.
  always @(negedge clk) begin
    if (modelValid) begin
      computeExpected();
      checkOutput("absjump_en", 32'(absjump_en), 32'(expEn));
      checkOutput("target", 32'(target), 32'(expTgt));
`ifdef JUMP_RAS_EN
      checkOutput("ras_depth", 32'(ras_depth), 32'(rasM.size()));
`else
      checkOutput("ras_depth", 32'(ras_depth), 32'd0);
`endif
      checkOutput("ovf_fault", 32'(ovf_fault), 32'(ovfM));
      checkOutput("unf_fault", 32'(unf_fault), 32'(unfM));
    end
  end

  task automatic idleInputs();
    reset     = 0;
    prog_ctr  = '0;
    jump_req  = 0;
    jump_cond = 0;
    call_req  = 0;
    ret_req   = 0;
    lut_idx   = '0;
    lut_we    = 0;
    lut_waddr = '0;
    lut_wdata = '0;
    fault_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // One random vector, biased so the stack both fills and drains.
  task automatic applyStimulus();
    reset     = ($urandom_range(99) == 0);
    prog_ctr  = ($urandom_range(9) == 0) ? 12'hFFF : 12'($urandom);
    ret_req   = ($urandom_range(99) < 30);
    call_req  = ($urandom_range(99) < 35);
    jump_req  = ($urandom_range(99) < 40);
    jump_cond = $urandom_range(1) == 1;
    lut_idx   = 4'($urandom);
    lut_we    = ($urandom_range(99) < 25);
    lut_waddr = ($urandom_range(3) == 0) ? lut_idx : 4'($urandom);
    lut_wdata = 12'($urandom);
    fault_clr = ($urandom_range(99) < 10);
    tick();
  endtask

  initial begin
    idleInputs();
    reset    = 1;
    call_req = 1;
    tick();
    tick();
    settle();
    checkOutput("reset_en", 32'(absjump_en), 32'd0);
    checkOutput("reset_depth", 32'(ras_depth), 32'd0);
    tick();

    // LUT write then conditional jump.
    idleInputs();
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 12'h2A0;
    tick();
    idleInputs();
    jump_req = 1; lut_idx = 4'd3; jump_cond = 1;
    settle();
    checkOutput("jump_taken_en", 32'(absjump_en), 32'd1);
    checkOutput("jump_taken_tgt", 32'(target), 32'h2A0);
    tick();
    jump_cond = 0;
    settle();
    checkOutput("jump_not_taken_en", 32'(absjump_en), 32'd0);
    checkOutput("jump_not_taken_tgt", 32'(target), 32'h000);
    tick();

    // Same-cycle write and read of one index returns the old entry.
    idleInputs();
    lut_we = 1; lut_waddr = 4'd5; lut_wdata = 12'h010;
    tick();
    idleInputs();
    lut_we = 1; lut_waddr = 4'd5; lut_wdata = 12'h077;
    call_req = 1; lut_idx = 4'd5; prog_ctr = 12'h050;
    settle();
    checkOutput("no_bypass_tgt", 32'(target), 32'h010);
    tick();
    idleInputs();
    jump_req = 1; jump_cond = 1; lut_idx = 4'd5;
    settle();
    checkOutput("after_write_tgt", 32'(target), 32'h077);
    tick();
    idleInputs();
    ret_req = 1;
    settle();
`ifdef JUMP_RAS_EN
    checkOutput("ret_after_call_tgt", 32'(target), 32'h051);
`else
    checkOutput("ret_ignored_en", 32'(absjump_en), 32'd0);
`endif
    tick();

`ifdef JUMP_RAS_EN
    // Nested calls and returns.
    idleInputs();
    lut_we = 1; lut_waddr = 4'd1; lut_wdata = 12'h300;
    tick();
    idleInputs();
    call_req = 1; lut_idx = 4'd1; prog_ctr = 12'h100;
    tick();
    checkOutput("nest_depth1", 32'(ras_depth), 32'd1);
    prog_ctr = 12'h200;
    tick();
    checkOutput("nest_depth2", 32'(ras_depth), 32'd2);
    idleInputs();
    ret_req = 1;
    settle();
    checkOutput("nest_ret1_tgt", 32'(target), 32'h201);
    tick();
    checkOutput("nest_depth3", 32'(ras_depth), 32'd1);
    settle();
    checkOutput("nest_ret2_tgt", 32'(target), 32'h101);
    tick();
    checkOutput("nest_depth4", 32'(ras_depth), 32'd0);

    // Overflow on the fifth call, then clear.
    idleInputs();
    call_req = 1; lut_idx = 4'd1;
    for (int i = 0; i < 4; i++) begin
      prog_ctr = 12'h010 + 12'(i);
      tick();
    end
    prog_ctr = 12'h014;
    settle();
    checkOutput("ovf_call_en", 32'(absjump_en), 32'd0);
    tick();
    checkOutput("ovf_flag", 32'(ovf_fault), 32'd1);
    checkOutput("ovf_depth", 32'(ras_depth), 32'd4);
    idleInputs();
    fault_clr = 1;
    tick();
    checkOutput("ovf_cleared", 32'(ovf_fault), 32'd0);

    // Drain to depth 1, then all three requests together: return wins.
    idleInputs();
    ret_req = 1;
    tick(); tick(); tick();
    call_req = 1; jump_req = 1; jump_cond = 1; lut_idx = 4'd1;
    settle();
    checkOutput("prio_tgt", 32'(target), 32'h011);
    tick();
    checkOutput("prio_depth", 32'(ras_depth), 32'd0);

    // Underflow, then wrap of the pushed return address.
    idleInputs();
    ret_req = 1;
    settle();
    checkOutput("unf_en", 32'(absjump_en), 32'd0);
    tick();
    checkOutput("unf_flag", 32'(unf_fault), 32'd1);
    idleInputs();
    call_req = 1; lut_idx = 4'd1; prog_ctr = 12'hFFF;
    tick();
    idleInputs();
    ret_req = 1;
    settle();
    checkOutput("wrap_tgt", 32'(target), 32'h000);
    checkOutput("wrap_en", 32'(absjump_en), 32'd1);
    tick();

    // Reset mid-sequence discards the stack and the LUT.
    idleInputs();
    call_req = 1; lut_idx = 4'd1;
    tick(); tick(); tick();
    reset = 1;
    settle();
    checkOutput("rst_mid_en", 32'(absjump_en), 32'd0);
    tick();
    idleInputs();
    jump_req = 1; jump_cond = 1; lut_idx = 4'd1;
    settle();
    checkOutput("rst_mid_depth", 32'(ras_depth), 32'd0);
    checkOutput("rst_mid_lut_tgt", 32'(target), 32'h000);
    tick();
`else
    // Without the stack, call is a plain jump and return only blocks.
    idleInputs();
    call_req = 1; lut_idx = 4'd5;
    settle();
    checkOutput("call_as_jump_en", 32'(absjump_en), 32'd1);
    checkOutput("call_as_jump_tgt", 32'(target), 32'h077);
    tick();
    ret_req = 1;
    settle();
    checkOutput("ret_blocks_en", 32'(absjump_en), 32'd0);
    checkOutput("norass_depth", 32'(ras_depth), 32'd0);
    tick();
    idleInputs();
    reset = 1; jump_req = 1; jump_cond = 1; lut_idx = 4'd5;
    settle();
    checkOutput("rst_en", 32'(absjump_en), 32'd0);
    tick();
    reset = 0;
    settle();
    checkOutput("rst_lut_tgt", 32'(target), 32'h000);
    tick();
`endif

    for (int c = 0; c < 3000; c++) applyStimulus();

    idleInputs();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
